// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined RV32 core.
// Each load/store request is latched in IDLE. The access happens after
// WAIT_CYCLES wait states, and the result is presented for one cycle in DONE.
// Byte/half/word lane steering, load extension and access-error detection are
// all computed from the latched copy of the request.
module dmem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  mem_stall,
    output logic                  resp_valid,
    output logic                  acc_err
);

    localparam int          WORDS    = 2 ** (DM_ADDRESS - 2);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [3:0]              cnt_r;
    logic [3:0]              cnt_nxt_s;
    logic                    latch_s;
    logic                    access_s;

    logic [DM_ADDRESS-1:0]   addr_r;
    logic [DATA_W-1:0]       wdata_r;
    logic [2:0]              func3_r;
    logic                    store_r;
    logic                    both_r;

    logic [DATA_W-1:0]       mem_r [0:WORDS-1];
    logic [DM_ADDRESS-3:0]   idx_s;
    logic [DATA_W-1:0]       word_s;
    logic [7:0]              byte_s;
    logic [15:0]             half_s;
    logic [DATA_W-1:0]       load_s;
    logic                    illegal_s;
    logic                    misalign_s;
    logic                    err_s;
    logic [3:0]              be_s;
    logic [DATA_W-1:0]       wlane_s;
    logic                    wr_en_s;

    assign idx_s   = addr_r[DM_ADDRESS-1:2];
    assign word_s  = mem_r[idx_s];
    assign err_s   = illegal_s | misalign_s;
    // Reset on the access edge discards a pending store.
    assign wr_en_s = access_s & store_r & ~err_s & ~reset;

    // FSM state and wait-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic, combinational stall request, latch and access strobes.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        access_s    = 1'b0;
        mem_stall   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    mem_stall   = 1'b1;
                    latch_s     = 1'b1;
                    cnt_nxt_s   = CNT_INIT;
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                if (cnt_r != 4'd0) begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end else begin
                    access_s    = 1'b1;
                    state_nxt_s = S_DONE;
                end
            end
            S_DONE: begin
                // The core still holds the same request here, so it is ignored.
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Capture the request so later input changes during the stall are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r  <= '0;
            wdata_r <= '0;
            func3_r <= 3'd0;
            store_r <= 1'b0;
            both_r  <= 1'b0;
        end else if (latch_s) begin
            addr_r  <= addr;
            wdata_r <= wr_data;
            func3_r <= func3;
            store_r <= MemWrite;
            both_r  <= MemRead & MemWrite;
        end
    end

    // Classify the latched access as illegal encoding or misaligned.
    always_comb begin
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        if (func3_r[1:0] == 2'b11) begin
            illegal_s = 1'b1;
        end else if (store_r && func3_r[2]) begin
            illegal_s = 1'b1;
        end else if (!store_r && (func3_r == 3'b110)) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = 1'b0;
        end
        case (func3_r[1:0])
            2'b01:   misalign_s = addr_r[0];
            2'b10:   misalign_s = (addr_r[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
    end

    // Pick the addressed byte of the stored word.
    always_comb begin
        byte_s = word_s[7:0];
        case (addr_r[1:0])
            2'd0:    byte_s = word_s[7:0];
            2'd1:    byte_s = word_s[15:8];
            2'd2:    byte_s = word_s[23:16];
            2'd3:    byte_s = word_s[31:24];
            default: byte_s = word_s[7:0];
        endcase
    end

    // Load extension: sign- or zero-extend the selected byte or half.
    always_comb begin
        half_s = addr_r[1] ? word_s[31:16] : word_s[15:0];
        load_s = 32'd0;
        case (func3_r)
            3'b000:  load_s = {{24{byte_s[7]}}, byte_s};
            3'b100:  load_s = {24'd0, byte_s};
            3'b001:  load_s = {{16{half_s[15]}}, half_s};
            3'b101:  load_s = {16'd0, half_s};
            3'b010:  load_s = word_s;
            default: load_s = 32'd0;
        endcase
    end

    // Store lane enables and the replicated store data.
    always_comb begin
        be_s    = 4'b0000;
        wlane_s = wdata_r;
        case (func3_r[1:0])
            2'b00: begin
                be_s    = 4'b0001 << addr_r[1:0];
                wlane_s = {4{wdata_r[7:0]}};
            end
            2'b01: begin
                be_s    = addr_r[1] ? 4'b1100 : 4'b0011;
                wlane_s = {2{wdata_r[15:0]}};
            end
            2'b10: begin
                be_s    = 4'b1111;
                wlane_s = wdata_r;
            end
            default: begin
                be_s    = 4'b0000;
                wlane_s = wdata_r;
            end
        endcase
    end

    // Storage array, byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
    end

    // Registered response: data, completion pulse and error pulse for DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data    <= '0;
            resp_valid <= 1'b0;
            acc_err    <= 1'b0;
        end else begin
            resp_valid <= access_s;
            acc_err    <= access_s & (err_s | both_r);
            if (access_s) begin
                rd_data <= (store_r || err_s) ? 32'd0 : load_s;
            end
        end
    end

endmodule
